// File: rtl/clint_pkg.sv
// clint_pkg: CLINT register offsets, size codes, bus widths
// and the byte-lane write-merge helper.
package clint_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int SIZE_WIDTH     = 2;
  localparam int REG_DATA_WIDTH = 32;
  localparam int BUS_DATA_WIDTH = 64;
  localparam int WORD_WIDTH     = 32;

  // word offsets, i.e. byte offset >> 2
  localparam logic [13:0] OFF_MSIP        = 14'h0000;
  localparam logic [13:0] OFF_MTIMECMP_LO = 14'h1000;
  localparam logic [13:0] OFF_MTIMECMP_HI = 14'h1001;
  localparam logic [13:0] OFF_MTIME_LO    = 14'h2FFE;
  localparam logic [13:0] OFF_MTIME_HI    = 14'h2FFF;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  // lanes past byte 3 fall off the word
  function automatic logic [31:0] lane_merge(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] r;
    int          n;
    r = old;
    case (size)
      SZ_BYTE: n = 1;
      SZ_HALF: n = 2;
      default: n = 4;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(lane) && i < int'(lane) + n)
        r[8*i +: 8] = data[8*(i - int'(lane)) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// clint_mtime_counter: tick prescaler and 64-bit mtime
// with per-half byte-lane writes.
module clint_mtime_counter
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [63:0] mtime
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] pre;
  logic          tick;

  assign tick = (pre == LAST);

  // a write to either half suppresses that cycle's increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      pre   <= '0;
      mtime <= '0;
    end else begin
      pre <= tick ? '0 : pre + CW'(1);
      if (wr_lo)
        mtime[31:0] <= lane_merge(mtime[31:0], wdata, size, lane);
      else if (wr_hi)
        mtime[63:32] <= lane_merge(mtime[63:32], wdata, size, lane);
      else if (tick)
        mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/clint.sv
// clint: core-local interruptor with msip, mtimecmp, mtime
// and registered timer/software interrupt lines.
module clint
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
  input  logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
  input  logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
  input  logic [REG_DATA_WIDTH-1:0] bus_clint_data,
  input  logic                      bus_clint_rd,
  input  logic                      bus_clint_wr,
  output logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
  output logic                      clint_mtip,
  output logic                      clint_msip
);

  logic [13:0] rsel;
  logic [13:0] wsel;
  logic [1:0]  lane;
  logic        wr_msip;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_mt_lo;
  logic        wr_mt_hi;
  logic        msip;
  logic [63:0] mtimecmp;
  logic [63:0] mtime;
  logic [31:0] msip_w;
  logic [31:0] rword;
  logic        unused_bits;

  assign rsel = bus_clint_read_addr[15:2];
  assign wsel = bus_clint_write_addr[15:2];
  assign lane = bus_clint_write_addr[1:0];

  assign wr_msip   = bus_clint_wr && (wsel == OFF_MSIP);
  assign wr_cmp_lo = bus_clint_wr && (wsel == OFF_MTIMECMP_LO);
  assign wr_cmp_hi = bus_clint_wr && (wsel == OFF_MTIMECMP_HI);
  assign wr_mt_lo  = bus_clint_wr && (wsel == OFF_MTIME_LO);
  assign wr_mt_hi  = bus_clint_wr && (wsel == OFF_MTIME_HI);

  assign msip_w = lane_merge({31'b0, msip}, bus_clint_data,
                             bus_clint_write_size, lane);

  assign unused_bits = ^{bus_clint_read_size,
                         bus_clint_read_addr[31:16],
                         bus_clint_read_addr[1:0],
                         bus_clint_write_addr[31:16],
                         msip_w[31:1]};

  clint_mtime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk   (clk),
    .rst   (rst),
    .wr_lo (wr_mt_lo),
    .wr_hi (wr_mt_hi),
    .wdata (bus_clint_data),
    .size  (bus_clint_write_size),
    .lane  (lane),
    .mtime (mtime)
  );

  always_comb begin
    rword = '0;
    unique case (1'b1)
      rsel == OFF_MSIP:        rword = {31'b0, msip};
      rsel == OFF_MTIMECMP_LO: rword = mtimecmp[31:0];
      rsel == OFF_MTIMECMP_HI: rword = mtimecmp[63:32];
      rsel == OFF_MTIME_LO:    rword = mtime[31:0];
      rsel == OFF_MTIME_HI:    rword = mtime[63:32];
      default:                 rword = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      msip           <= 1'b0;
      mtimecmp       <= '1;
      clint_bus_data <= '0;
      clint_mtip     <= 1'b0;
      clint_msip     <= 1'b0;
    end else begin
      if (wr_msip)
        msip <= msip_w[0];
      if (wr_cmp_lo)
        mtimecmp[31:0] <= lane_merge(mtimecmp[31:0], bus_clint_data,
                                     bus_clint_write_size, lane);
      if (wr_cmp_hi)
        mtimecmp[63:32] <= lane_merge(mtimecmp[63:32], bus_clint_data,
                                      bus_clint_write_size, lane);
      if (bus_clint_rd)
        clint_bus_data <= {{(BUS_DATA_WIDTH-WORD_WIDTH){1'b0}}, rword};
      clint_mtip <= (mtime >= mtimecmp);
      clint_msip <= msip;
    end
  end

endmodule
